// File: rtl/tlv2556_pkg.sv
// Shared types and constants for the TLV2556 serial ADC sequencer.
// Used by tlv2556_spi_seq and tlv2556_sclk_div.
package tlv2556_pkg;

  localparam int unsigned ADC_BITS = 12;
  localparam int unsigned CMD_BITS = 16;
  localparam int unsigned CH_BITS  = 4;

  localparam logic [1:0]         LEN_16     = 2'b11;
  localparam logic [CH_BITS-1:0] CH_REF_MID = 4'hB;
  localparam logic [CH_BITS-1:0] CH_REF_LO  = 4'hC;
  localparam logic [CH_BITS-1:0] CH_REF_HI  = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_WAIT_EOC
  } state_e;

  // Command word: channel, 16-clock frame, MSB first, unipolar.
  function automatic logic [CMD_BITS-1:0] build_cmd(input logic [CH_BITS-1:0] ch);
    return {ch, LEN_16, 1'b0, 1'b0, 8'h00};
  endfunction

endpackage

// File: rtl/tlv2556_sclk_div.sv
// SCLK generator: rises on the first enabled cycle boundary, CLK_DIV clk high then CLK_DIV clk low.
// rise_tick_c/fall_tick_c flag the cycle whose closing edge raises/lowers adc_sclk.
module tlv2556_sclk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned PERIOD = 2 * CLK_DIV;
  localparam int unsigned CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    cnt_d       = '0;
    sclk_d      = 1'b0;
    rise_tick_c = en && (cnt_q == '0);
    fall_tick_c = en && (cnt_q == CW'(CLK_DIV));
    if (en) begin
      cnt_d  = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
      sclk_d = rise_tick_c ? 1'b1 : (fall_tick_c ? 1'b0 : sclk_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/tlv2556_spi_seq.sv
// TLV2556 frame sequencer: sends the command, collects the pipelined result and waits for EOC.
// Optional TLV2556_AUTOSCAN_EN adds scan_en and an automatic 0..SCAN_LAST channel scan.
module tlv2556_spi_seq
  import tlv2556_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned EOC_TIMEOUT = 1024
`ifdef TLV2556_AUTOSCAN_EN
  ,
  parameter int unsigned SCAN_LAST   = 10
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CH_BITS-1:0]  channel,
`ifdef TLV2556_AUTOSCAN_EN
  input  logic                scan_en,
`endif
  output logic                busy,
  output logic                result_valid,
  output logic [ADC_BITS-1:0] result,
  output logic [CH_BITS-1:0]  result_ch,
  output logic                timeout_err,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                adc_din,
  input  logic                adc_dout,
  input  logic                adc_eoc
);

  localparam int unsigned SW     = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam int unsigned TW     = (EOC_TIMEOUT > 1) ? $clog2(EOC_TIMEOUT) : 1;
  localparam int unsigned BIT_CW = $clog2(CMD_BITS);

  state_e                state_q, state_d;
  logic [SW-1:0]         setup_cnt_q, setup_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [CMD_BITS-1:0]   rx_q, rx_d;
  logic [CH_BITS-1:0]    cur_ch_q, cur_ch_d;
  logic [CH_BITS-1:0]    prev_ch_q, prev_ch_d;
  logic                  prime_q, prime_d;
  logic                  busy_q, busy_d;
  logic                  result_valid_q, result_valid_d;
  logic [ADC_BITS-1:0]   result_q, result_d;
  logic [CH_BITS-1:0]    result_ch_q, result_ch_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  cs_n_q, cs_n_d;
  logic                  din_q, din_d;
  logic [1:0]            dout_sync_q, dout_sync_d;
  logic [1:0]            eoc_sync_q, eoc_sync_d;
  logic [1:0]            rise_pipe_q, rise_pipe_d;

  logic                  go_c;
  logic [CH_BITS-1:0]    ch_sel_c;
  logic                  setup_done_c;
  logic                  sclk_en_c;
  logic                  rise_tick_c;
  logic                  fall_tick_c;

`ifdef TLV2556_AUTOSCAN_EN
  logic [CH_BITS-1:0]    scan_ch_q, scan_ch_d;
  assign go_c     = start || scan_en;
  assign ch_sel_c = scan_en ? scan_ch_q : channel;
`else
  assign go_c     = start;
  assign ch_sel_c = channel;
`endif

  assign setup_done_c = (setup_cnt_q == SW'(CS_SETUP - 1));
  // Enabled one cycle before SHIFT so the first SCLK rise lands exactly CS_SETUP clk after CS_N falls.
  assign sclk_en_c    = (state_q == ST_SHIFT) || ((state_q == ST_SETUP) && setup_done_c);

  tlv2556_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk        (clk),
    .rst        (rst),
    .en         (sclk_en_c),
    .sclk       (adc_sclk),
    .rise_tick_c(rise_tick_c),
    .fall_tick_c(fall_tick_c)
  );

  always_comb begin
    state_d        = state_q;
    setup_cnt_d    = setup_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    cmd_d          = cmd_q;
    rx_d           = rx_q;
    cur_ch_d       = cur_ch_q;
    prev_ch_d      = prev_ch_q;
    prime_d        = prime_q;
    result_valid_d = 1'b0;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    timeout_err_d  = timeout_err_q;
    cs_n_d         = cs_n_q;
    din_d          = din_q;
    dout_sync_d    = {dout_sync_q[0], adc_dout};
    eoc_sync_d     = {eoc_sync_q[0], adc_eoc};
    rise_pipe_d    = {rise_pipe_q[0], rise_tick_c};
`ifdef TLV2556_AUTOSCAN_EN
    scan_ch_d      = scan_ch_q;
`endif

    // Sample two clk after each rise: that is the pin value at the rise, seen through the synchroniser.
    if (rise_pipe_q[1]) begin
      rx_d = {rx_q[CMD_BITS-2:0], dout_sync_q[1]};
    end

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        din_d  = 1'b0;
`ifdef TLV2556_AUTOSCAN_EN
        if (scan_en) begin
          scan_ch_d = (scan_ch_q == CH_BITS'(SCAN_LAST)) ? '0 : scan_ch_q + CH_BITS'(1);
        end else begin
          scan_ch_d = '0;
        end
`endif
        if (go_c) begin
          cur_ch_d      = ch_sel_c;
          cmd_d         = build_cmd(ch_sel_c);
          timeout_err_d = 1'b0;
          cs_n_d        = 1'b0;
          din_d         = cmd_d[CMD_BITS-1];
          setup_cnt_d   = '0;
          bit_cnt_d     = '0;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_done_c) begin
          state_d = ST_SHIFT;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      ST_SHIFT: begin
        if (fall_tick_c) begin
          cmd_d     = {cmd_q[CMD_BITS-2:0], 1'b0};
          din_d     = cmd_q[CMD_BITS-2];
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
          if (bit_cnt_q == BIT_CW'(CMD_BITS - 1)) begin
            setup_cnt_d = '0;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (setup_done_c) begin
          cs_n_d    = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_EOC;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      ST_WAIT_EOC: begin
        if (eoc_sync_q[1]) begin
          if (prime_q) begin
            result_d       = rx_q[CMD_BITS-1 -: ADC_BITS];
            result_ch_d    = prev_ch_q;
            result_valid_d = 1'b1;
          end
          prime_d   = 1'b1;
          prev_ch_d = cur_ch_q;
          state_d   = ST_IDLE;
        end else if (tmo_cnt_q == TW'(EOC_TIMEOUT - 1)) begin
          // Pipeline contents are stale after a timeout; the next frame only re-primes.
          timeout_err_d = 1'b1;
          prime_d       = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      setup_cnt_q    <= '0;
      tmo_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      cmd_q          <= '0;
      rx_q           <= '0;
      cur_ch_q       <= '0;
      prev_ch_q      <= '0;
      prime_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_ch_q    <= '0;
      timeout_err_q  <= 1'b0;
      cs_n_q         <= 1'b1;
      din_q          <= 1'b0;
      dout_sync_q    <= '0;
      eoc_sync_q     <= '0;
      rise_pipe_q    <= '0;
`ifdef TLV2556_AUTOSCAN_EN
      scan_ch_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      setup_cnt_q    <= setup_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      cmd_q          <= cmd_d;
      rx_q           <= rx_d;
      cur_ch_q       <= cur_ch_d;
      prev_ch_q      <= prev_ch_d;
      prime_q        <= prime_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      timeout_err_q  <= timeout_err_d;
      cs_n_q         <= cs_n_d;
      din_q          <= din_d;
      dout_sync_q    <= dout_sync_d;
      eoc_sync_q     <= eoc_sync_d;
      rise_pipe_q    <= rise_pipe_d;
`ifdef TLV2556_AUTOSCAN_EN
      scan_ch_q      <= scan_ch_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign timeout_err  = timeout_err_q;
  assign adc_cs_n     = cs_n_q;
  assign adc_din      = din_q;

endmodule

// File: tb/tb_tlv2556_spi_seq.sv
// Bench for tlv2556_spi_seq: TLV2556 behavioural model, result scoreboard and directed frames.
// Define TLV2556_AUTOSCAN_EN to also exercise the channel scan.
module tb_tlv2556_spi_seq;

  typedef struct packed {
    logic [11:0] res;
    logic [3:0]  ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  channel = 4'h0;
  logic        busy, result_valid, timeout_err;
  logic [11:0] result;
  logic [3:0]  result_ch;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;
  logic        adc_eoc = 1'b0;
`ifdef TLV2556_AUTOSCAN_EN
  logic        scan_en = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];

  // ADC model controls (written by stimulus) and frame measurements (written by the model)
  logic [15:0] adc_word = 16'h0;
  logic        eoc_hold_low = 1'b0;
  logic [15:0] sh = 16'h0;
  logic [15:0] din_cap = 16'h0;
  int          cyc = 0;
  int          t_cs_fall = 0, t_cs_rise = 0, t_first_rise = 0, t_last_rise = 0, t_last_fall = 0;
  int          t_idle = 0;
  int          pulses = 0, bad_period = 0;
  int          eoc_at = 0;
  logic        eoc_armed = 1'b0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;

  tlv2556_spi_seq #(
    .CLK_DIV    (4),
    .CS_SETUP   (2),
    .EOC_TIMEOUT(1024)
`ifdef TLV2556_AUTOSCAN_EN
    ,
    .SCAN_LAST  (2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .channel     (channel),
`ifdef TLV2556_AUTOSCAN_EN
    .scan_en     (scan_en),
`endif
    .busy        (busy),
    .result_valid(result_valid),
    .result      (result),
    .result_ch   (result_ch),
    .timeout_err (timeout_err),
    .adc_cs_n    (adc_cs_n),
    .adc_sclk    (adc_sclk),
    .adc_din     (adc_din),
    .adc_dout    (adc_dout),
    .adc_eoc     (adc_eoc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // TLV2556 model: MSB out on CS_N fall, next bit after each SCLK fall, EOC high 40 clk after CS_N rise.
  always @(negedge clk) begin
    if (cs_prev && !adc_cs_n) begin
      t_cs_fall  = cyc;
      sh         = adc_word;
      adc_dout   = sh[15];
      adc_eoc    = 1'b0;
      eoc_armed  = 1'b0;
      pulses     = 0;
      bad_period = 0;
      din_cap    = 16'h0;
    end
    if (!cs_prev && adc_cs_n) begin
      t_cs_rise = cyc;
      eoc_at    = cyc + 40;
      eoc_armed = 1'b1;
    end
    if (!sclk_prev && adc_sclk) begin
      if (pulses == 0) t_first_rise = cyc;
      else if (cyc - t_last_rise != 8) bad_period++;
      t_last_rise = cyc;
      pulses++;
      din_cap = {din_cap[14:0], adc_din};
    end
    if (sclk_prev && !adc_sclk) begin
      t_last_fall = cyc;
      if (cyc - t_last_rise != 4) bad_period++;
      sh       = {sh[14:0], 1'b0};
      adc_dout = sh[15];
    end
    if (eoc_armed && adc_cs_n && cyc == eoc_at) begin
      eoc_armed = 1'b0;
      if (!eoc_hold_low) adc_eoc = 1'b1;
    end
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  // Scoreboard monitor: every valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && result_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_valid: got result=%h ch=%h, required no valid pulse", result, result_ch);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (result !== e.res || result_ch !== e.ch) begin
          n_bad++;
          $display("FAIL sb_result: got result=%h ch=%h, required result=%h ch=%h",
                   result, result_ch, e.res, e.ch);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t_idle = cyc;
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_frame(input logic [3:0] ch, input logic [15:0] word, input logic eoc_ok,
                          input string name);
    adc_word     = word;
    eoc_hold_low = !eoc_ok;
    @(negedge clk);
    channel = ch;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd0);
    check("rst_outs", 32'({result, result_ch, result_valid, timeout_err, adc_din}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Prime frame: no result, command 0x3C00, exact SCLK framing
    do_frame(4'h3, 16'hABC0, 1'b1, "prime");
    check("prime_din", 32'(din_cap), 32'h3C00);
    check("prime_pulses", 32'(pulses), 32'd16);
    check("prime_bad_period", 32'(bad_period), 32'd0);
    check("prime_cs_to_rise", 32'(t_first_rise - t_cs_fall), 32'd2);
    check("prime_fall_to_cs", 32'(t_cs_rise - t_last_fall), 32'd2);
    check("prime_eoc_wait", 32'((t_idle - t_cs_rise) >= 41 && (t_idle - t_cs_rise) <= 45), 32'd1);

    exp_q.push_back('{res: 12'h7FF, ch: 4'h3});
    do_frame(4'h5, 16'h7FF0, 1'b1, "pipe1");
    check("pipe1_din", 32'(din_cap), 32'h5C00);

    exp_q.push_back('{res: 12'h123, ch: 4'h5});
    do_frame(4'hB, 16'h1230, 1'b1, "refmid");
    check("refmid_din", 32'(din_cap), 32'hBC00);

    // EOC held low: timeout after exactly 1024 clk in WAIT_EOC, no result
    do_frame(4'h2, 16'hFFF0, 1'b0, "tmo");
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_latency", 32'(t_idle - t_cs_rise), 32'd1024);
    check("tmo_result_kept", 32'(result), 32'h123);

    // Frame after timeout only re-primes; the flag clears on that start
    do_frame(4'h4, 16'h5550, 1'b1, "reprime");
    check("reprime_err_clr", 32'(timeout_err), 32'd0);
    exp_q.push_back('{res: 12'h001, ch: 4'h4});
    do_frame(4'h6, 16'h0010, 1'b1, "after_reprime");

    // A start pulse while busy is dropped and its channel never used
    exp_q.push_back('{res: 12'h888, ch: 4'h6});
    adc_word     = 16'h8880;
    eoc_hold_low = 1'b0;
    @(negedge clk);
    channel = 4'h7;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    channel = 4'h9;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_ign");
    repeat (5) @(negedge clk);
    check("busy_ign_no_queue", 32'(busy), 32'd0);
    exp_q.push_back('{res: 12'h444, ch: 4'h7});
    do_frame(4'h1, 16'h4440, 1'b1, "after_ign");
    check("after_ign_din", 32'(din_cap), 32'h1C00);

    // Reset in the middle of SHIFT
    adc_word = 16'hEEE0;
    @(negedge clk);
    channel = 4'h8;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
    check("midrst_sclk", 32'(adc_sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_frame(4'h2, 16'h1110, 1'b1, "post_rst_prime");
    exp_q.push_back('{res: 12'h222, ch: 4'h2});
    do_frame(4'h3, 16'h2220, 1'b1, "post_rst_pipe");

`ifdef TLV2556_AUTOSCAN_EN
    // Scan 0,1,2,0 with no start pulses; channel input ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    adc_word = 16'hA5A0;
    exp_q.push_back('{res: 12'hA5A, ch: 4'h0});
    exp_q.push_back('{res: 12'hA5A, ch: 4'h1});
    exp_q.push_back('{res: 12'hA5A, ch: 4'h2});
    exp_q.push_back('{res: 12'hA5A, ch: 4'h0});
    channel = 4'h9;
    scan_en = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() > 1 && n < 3000) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("scan_progress", 32'(exp_q.size() <= 1), 32'd1);
    end
    scan_en = 1'b0;
    wait_idle("scan_stop");
`endif

    repeat (5) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
